uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//   Serial front end of the terminal: receives 8N1 UART bytes on i_rx and buffers them
//   in a FWFT FIFO. Presents them on a valid/ready stream to the character controller,
//   which stalls for many cycles during scroll/clear. Drops bytes on frame error or
//   overrun and flags them.
// PARAMETERS
//   CLK_HZ      12_000_000  system clock frequency
//   BAUD        115_200     line rate; CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD (=104)
//   FIFO_DEPTH  16          entries, power of 2, >= 4
//   AF_MARGIN   4           o_almost_full asserts when count >= FIFO_DEPTH - AF_MARGIN
// PORTS
//   i_clk          in   1  system clock, 12 MHz
//   i_rst          in   1  synchronous reset, active high
//   i_rx           in   1  asynchronous UART line, idle high
//   o_char         out  8  head-of-FIFO byte; valid only while o_valid
//   o_valid        out  1  FIFO not empty
//   i_ready        in   1  consumer accepts o_char this cycle
//   o_almost_full  out  1  level; used for host flow control (RTS)
//   o_frame_err    out  1  1-cycle pulse: stop bit sampled low, byte discarded
//   o_overrun      out  1  1-cycle pulse: byte completed while FIFO full, byte discarded
// BEHAVIOUR
//   Reset: all outputs 0, FIFO empty, receiver in IDLE, synchroniser regs = 1.
//   Input: 2-FF synchroniser on i_rx; the FSM sees only the synchronised rx_s.
//   Bit timer: counts 0..CLKS_PER_BIT-1 and reloads on every state entry.
//   FSM states:
//     IDLE  : rx_s==0 -> START, timer=0.
//     START : at CLKS_PER_BIT/2 (52) sample; 0 -> DATA (bit=0, timer=0); 1 -> IDLE (glitch).
//     DATA  : every CLKS_PER_BIT sample rx_s into shreg, LSB first; after bit 7 -> STOP.
//     STOP  : at CLKS_PER_BIT sample; 1 -> push byte, -> IDLE;
//             0 -> o_frame_err pulse, no push, -> WAIT_HIGH.
//     WAIT_HIGH : (break/line stuck low) stay until rx_s==1, then -> IDLE.
//   Sampling is mid-bit because START already consumed the half bit.
//   Push: 1 cycle when STOP samples 1 (the cycle after the stop-bit sample).
//   Pop: o_valid & i_ready; i_ready while !o_valid has no effect.
//   FWFT: o_char = mem[rd_ptr] combinationally from the registered array.
//     o_valid rises the cycle after the push.
//     The stream holds o_char/o_valid stable until accepted.
//   Count: log2(FIFO_DEPTH)+1 bits; pointers wrap naturally at FIFO_DEPTH.
//   Full + push + pop in the same cycle: push accepted, count unchanged, no overrun.
//   Full + push, no pop: byte dropped, o_overrun pulse, FIFO contents unchanged.
//   Empty + push + pop: the pop is ignored because o_valid=0; count becomes 1.
//   o_almost_full: registered from the next count; deasserts below the threshold.
//   Reset mid-frame: the partial byte is discarded, FIFO is flushed, and o_valid=0
//     the cycle after i_rst. A line still low after reset is treated as a start edge.
//   Max back-to-back rate: 1 byte / 10 bit times; no byte is lost while the FIFO is not full.
// STRUCTURE
//   Shared include serterm_defs.vh: CLK_HZ and BAUD defaults, shared with bel timing.
//   Sub-module uart_rx_bit: synchroniser + FSM + bit timer.
//     Outputs: byte[7:0], byte_stb, frame_err.
//   FIFO storage and pointers: inline in uart_rx_fifo; no vendor RAM primitive.
// TESTING
//   1. Send 0x41 at 115200 -> o_valid after stop bit; o_char=0x41; accept with i_ready=1
//      -> o_valid=0.
//   2. Send 16 bytes 0x30..0x3F with i_ready=0 -> count=16; o_almost_full from the 12th.
//      A 17th byte 0x55 -> o_overrun pulse and 0x55 absent.
//      Drain -> 0x30..0x3F in order.
//   3. Frame with stop bit forced 0 (0x7E) -> o_frame_err pulse, no push.
//      Line held low 3 frames, then 0x42 -> only 0x42 delivered.
//   4. 1/4-bit low glitch on idle line -> no push, no error; receiver back in IDLE.
//   5. Assert i_rst during data bit 4 of 0x99 with 3 bytes queued -> o_valid=0 next cycle.
//      Next clean frame 0x43 is received correctly.
//   6. FIFO full with i_ready=1 held while a new byte completes -> push+pop same cycle.
//      No overrun; output order is preserved.
//   Baud tolerance: ±2% line rate (102/106 clocks per bit) -> all bytes correct.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and line-rate helpers for the UART receive path.
// Also holds the default clock/baud pair used by the terminal.
package uart_rx_fifo_pkg;

  localparam int DEF_CLK_HZ = 12_000_000;
  localparam int DEF_BAUD   = 115_200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_bit.sv
// 8N1 bit-level receiver: input synchroniser, bit timer and framing FSM.
// Emits a one-cycle strobe per good byte and a pulse per bad stop bit.
module uart_rx_bit
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_stb,
  output logic       o_frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic            r_sync1;
  logic            r_sync2;
  rx_state_e       r_state;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_bit;
  logic [7:0]      r_shreg;
  logic            r_stb;
  logic            r_ferr;

  rx_state_e       w_state_n;
  logic [TW-1:0]   w_timer_n;
  logic [2:0]      w_bit_n;
  logic [7:0]      w_shreg_n;
  logic            w_stb_n;
  logic            w_ferr_n;
  logic            w_rx_s;

  assign w_rx_s = r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_stb   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_bit   <= w_bit_n;
      r_shreg <= w_shreg_n;
      r_stb   <= w_stb_n;
      r_ferr  <= w_ferr_n;
    end
  end

  // Timer is held at zero outside timed states so every entry starts fresh.
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer + TW'(1);
    w_bit_n   = r_bit;
    w_shreg_n = r_shreg;
    w_stb_n   = 1'b0;
    w_ferr_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_n = '0;
        if (!w_rx_s) w_state_n = S_START;
      end
      S_START: begin
        if (r_timer == HALF) begin
          w_timer_n = '0;
          w_bit_n   = '0;
          w_state_n = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_timer == LAST) begin
          w_timer_n = '0;
          w_shreg_n = {w_rx_s, r_shreg[7:1]};
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (r_timer == LAST) begin
          w_timer_n = '0;
          if (w_rx_s) begin
            w_stb_n   = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_ferr_n  = 1'b1;
            w_state_n = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_timer_n = '0;
        if (w_rx_s) w_state_n = S_IDLE;
      end
      default: begin
        w_timer_n = '0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign o_byte      = r_shreg;
  assign o_byte_stb  = r_stb;
  assign o_frame_err = r_ferr;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a first-word-fall-through FIFO with a
// valid/ready output stream, almost-full level and drop flags.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_char,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_almost_full,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW + 1)'(FIFO_DEPTH - AF_MARGIN);

  logic [7:0]    w_byte;
  logic          w_stb;
  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [AW:0]   w_count_n;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_af;
  logic          r_ov;

  uart_rx_bit #(
    .CLKS_PER_BIT(CPB)
  ) u_bit (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .o_byte     (w_byte),
    .o_byte_stb (w_stb),
    .o_frame_err(o_frame_err)
  );

  assign w_full  = (r_count == FULL_LVL);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & i_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push  = w_stb & (~w_full | w_pop);

  always_comb begin
    w_count_n = r_count;
    if (w_push & ~w_pop)      w_count_n = r_count + (AW + 1)'(1);
    else if (~w_push & w_pop) w_count_n = r_count - (AW + 1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_af     <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_n;
      r_af    <= (w_count_n >= AF_LVL);
      r_ov    <= w_stb & w_full & ~w_pop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_byte;
  end

  assign o_valid       = w_valid;
  assign o_char        = w_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign o_almost_full = r_af;
  assign o_overrun     = r_ov;

endmodule
